ip_output_arbiter: RTL and testbench
====================================

// Module: ip_output_arbiter
// PURPOSE
// - Shares one IP output header channel + payload byte stream among NUM_SRC FPGA-side requesters.
// - Round-robin grant per packet; grant held from header acceptance until payload tlast beat.
// - Sits between the user IP sources and the IP/Ethernet TX framer (header+payload consumer).
// PARAMETERS
// - NUM_SRC     4  number of requesters, 2..8
// - DATA_WIDTH  8  payload tdata width in bits
// PORTS
// - clk              in   1                      system clock, all logic on rising edge
// - rst_n            in   1                      asynchronous active-low reset
// - s_hdr_valid      in   NUM_SRC                per-source header valid
// - s_hdr_ready      out  NUM_SRC                per-source header ready
// - s_hdr            in   NUM_SRC x ip_hdr_t     per-source header fields (272 b each)
// - s_tdata          in   NUM_SRC x DATA_WIDTH   per-source payload data
// - s_tvalid         in   NUM_SRC                payload valid
// - s_tready         out  NUM_SRC                payload ready
// - s_tlast          in   NUM_SRC                payload last beat
// - m_hdr_valid      out  1                      header valid to framer
// - m_hdr_ready      in   1                      header ready from framer
// - m_hdr            out  ip_hdr_t               selected header
// - m_tdata          out  DATA_WIDTH             selected payload data
// - m_tvalid         out  1                      payload valid
// - m_tready         in   1                      payload ready
// - m_tlast          out  1                      payload last
// - grant_idx        out  $clog2(NUM_SRC)        current/last granted source
// - busy             out  1                      high in HDR or PAYLOAD state
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, grant_idx=0, busy=0; all valid/ready outputs 0; m_hdr, m_tdata 0.
// - FSM IDLE: if any s_hdr_valid, pick first set bit searching from rr_ptr upward, wrapping;
//   register grant_idx, go HDR. Arbitration latency 1 cycle (valid seen at edge N, m_hdr_valid at N+1).
// - FSM HDR: m_hdr_valid=s_hdr_valid[g], m_hdr=s_hdr[g], s_hdr_ready[g]=m_hdr_ready (combinational
//   from registered g). On valid&ready: go PAYLOAD, rr_ptr=(g+1) mod NUM_SRC.
// - FSM PAYLOAD: m_t* = s_t*[g], s_tready[g]=m_tready. On m_tvalid&m_tready&m_tlast: go IDLE.
//   One idle bubble between packets is intended.
// - Non-granted sources: hdr_ready=0, tready=0 in every state; no payload accepted before header.
// - Granted source deasserting hdr_valid in HDR: grant kept, m_hdr_valid follows it low (AXI
//   violation by source, not recovered). Header fields pass through unmodified; no checksum work.
// - Simultaneous requests: strict rotation, never starves; a lone requester is re-granted each packet.
// - Single-beat packet (tlast on first beat) legal: HDR->PAYLOAD->IDLE.
// - rr_ptr wrap: NUM_SRC-1 -> 0. m_hdr/m_tdata are don't-care when their valid is low; drive 0 in IDLE.
// - Reset mid-packet: immediate abort to reset values; framer discards partial packet.
// STRUCTURE
// - ip_arb_pkg: ip_hdr_t packed struct (eth_dest_mac 48, eth_src_mac 48, eth_type 16, version 4,
//   ihl 4, dscp 6, ecn 2, length 16, identification 16, flags 3, fragment_offset 13, ttl 8,
//   protocol 8, header_checksum 16, source_ip 32, dest_ip 32), state enum {IDLE,HDR,PAYLOAD}.
// - Sub-module rr_pick (combinational): req vector + ptr -> found flag + index; reusable elsewhere.
// - Top-level wrapper adapts IP_OUTPUT_HEADER_IF Input/Output modports to flat ports.
// TESTING
// - Reset mid-PAYLOAD on src 2 -> next cycle all outputs 0, busy=0, grant_idx=0.
// - Only src1 valid, 4-beat payload 0xA1..0xA4 -> m_hdr_valid 1 cycle later, 4 beats out, tlast on 0xA4.
// - src0..3 all valid, back-to-back -> grant order 0,1,2,3,0; no source skipped.
// - rr_ptr=3 after src2, requests on 0 and 3 -> src3 granted first, then src0.
// - m_hdr_ready low 5 cycles -> m_hdr stable, s_hdr_ready[g]=0 throughout, no payload moves.
// - Random m_tready stalls + single-beat packets on all sources -> scoreboard order/data exact.

Source files
------------

// File: rtl/ip_output_arbiter_pkg.sv
// Shared types for the IP output arbiter: the IP/Ethernet header record carried
// on the header channel, and the arbiter FSM state.
package ip_arb_pkg;

  typedef struct packed {
    logic [47:0] eth_dest_mac;
    logic [47:0] eth_src_mac;
    logic [15:0] eth_type;
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] length;
    logic [15:0] identification;
    logic [2:0]  flags;
    logic [12:0] fragment_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] header_checksum;
    logic [31:0] source_ip;
    logic [31:0] dest_ip;
  } ip_hdr_t;

  localparam int unsigned IP_HDR_W = $bits(ip_hdr_t);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } arb_state_e;

endpackage

// File: rtl/ip_output_arbiter_if.sv
// Bundle of NUM_SRC requester channels plus the single framer-facing channel.
// master = requesters and framer side, slave = the arbiter.
interface ip_output_arbiter_if
  import ip_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [NUM_SRC-1:0]                 s_hdr_valid;
  logic [NUM_SRC-1:0]                 s_hdr_ready;
  ip_hdr_t [NUM_SRC-1:0]              s_hdr;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] s_tdata;
  logic [NUM_SRC-1:0]                 s_tvalid;
  logic [NUM_SRC-1:0]                 s_tready;
  logic [NUM_SRC-1:0]                 s_tlast;

  logic                               m_hdr_valid;
  logic                               m_hdr_ready;
  ip_hdr_t                            m_hdr;
  logic [DATA_WIDTH-1:0]              m_tdata;
  logic                               m_tvalid;
  logic                               m_tready;
  logic                               m_tlast;

  modport master (
    output s_hdr_valid, s_hdr, s_tdata, s_tvalid, s_tlast, m_hdr_ready, m_tready,
    input  s_hdr_ready, s_tready, m_hdr_valid, m_hdr, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    input  s_hdr_valid, s_hdr, s_tdata, s_tvalid, s_tlast, m_hdr_ready, m_tready,
    output s_hdr_ready, s_tready, m_hdr_valid, m_hdr, m_tdata, m_tvalid, m_tlast
  );

endinterface

// File: rtl/ip_output_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned  N = 4,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  int unsigned      k;
  logic [W-1:0]     kk;

  // Scan from the farthest offset back to ptr_i so the nearest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    k       = 0;
    kk      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(ptr_i) + (N - 1 - i);
      if (k >= N) k = k - N;
      kk = W'(k);
      if (req_i[kk]) begin
        found_o = 1'b1;
        idx_o   = kk;
      end
    end
  end

endmodule

// File: rtl/ip_output_arbiter.sv
// Packet-level round-robin arbiter sharing one IP header + payload stream among
// NUM_SRC requesters; grant is held from header acceptance through tlast.
module ip_output_arbiter
  import ip_arb_pkg::*;
#(
  parameter int unsigned  NUM_SRC    = 4,
  parameter int unsigned  DATA_WIDTH = 8,
  localparam int unsigned IDX_W      = $clog2(NUM_SRC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ip_output_arbiter_if.slave     bus,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy
);

  arb_state_e       state_q,  state_d;
  logic [IDX_W-1:0] grant_q,  grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             hdr_fire;
  logic             last_fire;

  rr_pick #(.N(NUM_SRC)) u_rr_pick (
    .req_i   (bus.s_hdr_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_ptr_d        = rr_ptr_q;
    hdr_fire        = 1'b0;
    last_fire       = 1'b0;
    bus.s_hdr_ready = '0;
    bus.s_tready    = '0;
    bus.m_hdr_valid = 1'b0;
    bus.m_hdr       = '0;
    bus.m_tdata     = '0;
    bus.m_tvalid    = 1'b0;
    bus.m_tlast     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = HDR;
        end
      end

      HDR: begin
        bus.m_hdr_valid          = bus.s_hdr_valid[grant_q];
        bus.m_hdr                = bus.s_hdr[grant_q];
        bus.s_hdr_ready[grant_q] = bus.m_hdr_ready;
        hdr_fire                 = bus.s_hdr_valid[grant_q] & bus.m_hdr_ready;
        if (hdr_fire) begin
          state_d  = PAYLOAD;
          rr_ptr_d = (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end

      PAYLOAD: begin
        bus.m_tdata           = bus.s_tdata[grant_q];
        bus.m_tvalid          = bus.s_tvalid[grant_q];
        bus.m_tlast           = bus.s_tlast[grant_q];
        bus.s_tready[grant_q] = bus.m_tready;
        last_fire             = bus.s_tvalid[grant_q] & bus.m_tready & bus.s_tlast[grant_q];
        if (last_fire) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ip_output_arbiter.sv
// Bench for ip_output_arbiter: per-source packet queues drive the requesters and a
// packet-level round-robin model predicts the granted source, header and payload.
`timescale 1ns/1ps
module tb_ip_output_arbiter;
  import ip_arb_pkg::*;

  localparam int NS   = 4;
  localparam int DW   = 8;
  localparam int MAXP = 8;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    grant_idx;
  logic          busy;

  always #5 clk = ~clk;

  ip_output_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

  ip_output_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Packet store shared by the requester drivers and the reference model
  ip_hdr_t        phdr [NS][MAXP];
  int             plen [NS][MAXP];
  logic [DW-1:0]  pdat [NS][MAXP][MAXB];
  int             npk  [NS];
  int             sent [NS];
  int             sbeat[NS];
  bit             inpay[NS];

  // Reference model: packets not yet granted, rotation pointer, packet in flight
  int             rem  [NS];
  int             exp_ptr;
  int             mcur, mk, mbeat;
  bit             mactive;
  int             order[$];

  task automatic chk(string tag, logic [271:0] got, logic [271:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ip_hdr_t rand_hdr();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
    return ip_hdr_t'(t[271:0]);
  endfunction

  task automatic clear_pkts();
    for (int s = 0; s < NS; s++) begin
      npk[s] = 0; sent[s] = 0; sbeat[s] = 0; inpay[s] = 0; rem[s] = 0;
    end
    mactive = 0;
  endtask

  task automatic add_pkt(int s, int len, bit seq, logic [DW-1:0] base);
    int k;
    k = npk[s];
    phdr[s][k] = rand_hdr();
    plen[s][k] = len;
    for (int b = 0; b < len; b++) pdat[s][k][b] = seq ? base + DW'(b) : DW'($urandom());
    npk[s]++;
    rem[s]++;
  endtask

  task automatic idle_inputs();
    bus.s_hdr_valid = '0;
    bus.s_hdr       = '0;
    bus.s_tdata     = '0;
    bus.s_tvalid    = '0;
    bus.s_tlast     = '0;
    bus.m_hdr_ready = 1'b0;
    bus.m_tready    = 1'b0;
  endtask

  task automatic drive_srcs();
    int k;
    for (int s = 0; s < NS; s++) begin
      bus.s_hdr_valid[s] = 1'b0;
      bus.s_hdr[s]       = '0;
      bus.s_tvalid[s]    = 1'b0;
      bus.s_tdata[s]     = '0;
      bus.s_tlast[s]     = 1'b0;
      if (inpay[s]) begin
        k = sent[s] - 1;
        bus.s_tvalid[s] = 1'b1;
        bus.s_tdata[s]  = pdat[s][k][sbeat[s]];
        bus.s_tlast[s]  = (sbeat[s] == plen[s][k] - 1);
      end else if (sent[s] < npk[s]) begin
        bus.s_hdr_valid[s] = 1'b1;
        bus.s_hdr[s]       = phdr[s][sent[s]];
      end
    end
  endtask

  function automatic bit all_done();
    bit d;
    d = !mactive;
    for (int s = 0; s < NS; s++)
      if (rem[s] != 0 || sent[s] != npk[s] || inpay[s]) d = 0;
    return d;
  endfunction

  // Called between edges: judges the handshakes that the next rising edge will take
  task automatic observe();
    logic [NS-1:0] one, allowed;
    int e, c;
    one     = 1;
    allowed = mactive ? (one << mcur) : '0;
    chk("tready_isolation", bus.s_tready & ~allowed, '0);
    chk("hdr_ready_onehot", $countones(bus.s_hdr_ready) <= 1, 1);
    if (mactive) chk("hdr_ready_in_payload", bus.s_hdr_ready, '0);

    if (bus.m_hdr_valid && bus.m_hdr_ready) begin
      e = -1;
      for (int i = 0; i < NS; i++) begin
        c = (exp_ptr + i) % NS;
        if (e < 0 && rem[c] > 0) e = c;
      end
      chk("hdr_while_active", mactive, 0);
      chk("hdr_expected", e >= 0, 1);
      if (e >= 0) begin
        chk("grant_idx", grant_idx, e);
        chk("m_hdr", bus.m_hdr, phdr[e][npk[e] - rem[e]]);
        order.push_back(int'(grant_idx));
        mcur = e; mk = npk[e] - rem[e]; mbeat = 0; mactive = 1;
        rem[e]--;
        exp_ptr = (e + 1) % NS;
      end
    end

    if (bus.m_tvalid && bus.m_tready) begin
      chk("beat_after_hdr", mactive, 1);
      if (mactive) begin
        chk("m_tdata", bus.m_tdata, pdat[mcur][mk][mbeat]);
        chk("m_tlast", bus.m_tlast, mbeat == plen[mcur][mk] - 1);
        if (mbeat == plen[mcur][mk] - 1) mactive = 0;
        else mbeat++;
      end
    end

    for (int s = 0; s < NS; s++) begin
      if (bus.s_hdr_valid[s] && bus.s_hdr_ready[s]) begin
        sent[s]++; inpay[s] = 1; sbeat[s] = 0;
      end else if (bus.s_tvalid[s] && bus.s_tready[s]) begin
        if (bus.s_tlast[s]) inpay[s] = 0;
        else sbeat[s]++;
      end
    end
  endtask

  task automatic run(int budget, int hp, int tp);
    int cyc;
    cyc = 0;
    while (!all_done() && cyc < budget) begin
      @(negedge clk);
      drive_srcs();
      bus.m_hdr_ready = ($urandom_range(99) < hp);
      bus.m_tready    = ($urandom_range(99) < tp);
      #1 observe();
      cyc++;
    end
    chk("traffic_drained", all_done(), 1);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_m_hdr_valid", bus.m_hdr_valid, 0);
    chk("rst_m_hdr", bus.m_hdr, '0);
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    chk("rst_m_tdata", bus.m_tdata, '0);
    chk("rst_m_tlast", bus.m_tlast, 0);
    chk("rst_s_hdr_ready", bus.s_hdr_ready, '0);
    chk("rst_s_tready", bus.s_tready, '0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_a[5];
    int n, len;
    bit reached;

    idle_inputs();
    clear_pkts();
    exp_ptr = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    // All four requesting back to back, src0 has a second packet
    clear_pkts();
    add_pkt(0, 2, 0, '0); add_pkt(0, 2, 0, '0);
    for (int s = 1; s < NS; s++) add_pkt(s, 3, 0, '0);
    order.delete();
    run(300, 100, 100);
    exp_a = '{0, 1, 2, 3, 0};
    chk("rr_order_len", order.size(), 5);
    if (order.size() == 5)
      for (int i = 0; i < 5; i++) chk("rr_order", order[i], exp_a[i]);

    // Lone src1, four beats 0xA1..0xA4, arbitration latency
    clear_pkts();
    add_pkt(1, 4, 1, 8'hA1);
    @(negedge clk);
    drive_srcs(); bus.m_hdr_ready = 1'b0; bus.m_tready = 1'b1;
    #1 chk("lat_hdr_valid_pre", bus.m_hdr_valid, 0);
    chk("lat_busy_pre", busy, 0);
    @(negedge clk);
    drive_srcs();
    #1 chk("lat_hdr_valid", bus.m_hdr_valid, 1);
    chk("lat_grant", grant_idx, 1);
    chk("lat_busy", busy, 1);
    order.delete();
    run(100, 100, 100);
    chk("src1_granted", order.size() == 1 && order[0] == 1, 1);

    // Pointer at 3 after serving src2, then src0 and src3 compete
    clear_pkts();
    add_pkt(2, 1, 0, '0);
    run(50, 100, 100);
    clear_pkts();
    add_pkt(0, 2, 0, '0); add_pkt(3, 2, 0, '0);
    order.delete();
    run(100, 100, 100);
    chk("ptr3_count", order.size(), 2);
    if (order.size() == 2) begin
      chk("ptr3_first", order[0], 3);
      chk("ptr3_second", order[1], 0);
    end

    // Framer holds off the header for five cycles
    clear_pkts();
    add_pkt(0, 2, 0, '0);
    @(negedge clk);
    drive_srcs(); bus.m_hdr_ready = 1'b0; bus.m_tready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      drive_srcs(); bus.m_hdr_ready = 1'b0;
      #1 chk("stall_m_hdr", bus.m_hdr, phdr[0][0]);
      chk("stall_hdr_valid", bus.m_hdr_valid, 1);
      chk("stall_s_hdr_ready", bus.s_hdr_ready, '0);
      chk("stall_m_tvalid", bus.m_tvalid, 0);
      chk("stall_s_tready", bus.s_tready, '0);
    end
    run(100, 100, 100);

    // Random backpressure, mostly single-beat packets on every source
    repeat (3) begin
      clear_pkts();
      for (int s = 0; s < NS; s++) begin
        n = $urandom_range(1, 5);
        for (int p = 0; p < n; p++) begin
          len = ($urandom_range(3) == 0) ? $urandom_range(2, 4) : 1;
          add_pkt(s, len, 0, '0);
        end
      end
      run(3000, 60, 50);
    end

    // Reset asserted mid-payload on src2
    clear_pkts();
    add_pkt(2, 6, 0, '0);
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      @(negedge clk);
      drive_srcs(); bus.m_hdr_ready = 1'b1; bus.m_tready = 1'b1;
      #1 observe();
      if (mactive && mbeat == 2) reached = 1;
    end
    chk("midpkt_reached", reached, 1);
    @(posedge clk);
    drive_srcs();
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    chk_reset_outputs();
    idle_inputs();
    clear_pkts();
    exp_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // After reset the rotation restarts from source 0
    add_pkt(2, 1, 0, '0); add_pkt(3, 1, 0, '0);
    order.delete();
    run(100, 100, 100);
    chk("post_reset_first", order.size() >= 1 && order[0] == 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
